// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: sequences a set of downstream reset domains.
// All domains are put into reset and must acknowledge. They are then held for a
// fixed time and released one at a time in ascending order, each release waiting
// for that domain's acknowledge to drop. A missing acknowledge ends in a sticky
// error that records the offending domain. Every output is a registered decode
// of the next state, so nothing downstream sees combinational glitches.
module rst_seq_ctrl #(
    parameter int NumDomains   = 4,
    parameter int HoldCycles   = 16,
    parameter int AckTimeout   = 255,
    parameter int SyncRegWidth = 2,
    localparam int DomW        = (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic [NumDomains-1:0] i_ack,
    output logic [NumDomains-1:0] o_rst_n,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [DomW-1:0]       o_err_domain
);

    localparam int CntMax = (HoldCycles > AckTimeout) ? HoldCycles : AckTimeout;
    localparam int CntW   = $clog2(CntMax + 1);

    // Terminal counter values: the counter holds "cycles already spent", so the
    // last permitted cycle in a state is the one where it equals limit-1.
    localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] AckLast  = CntW'(AckTimeout - 1);
    localparam logic [DomW-1:0] DomLast  = DomW'(NumDomains - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_HOLD,
        S_RELEASE,
        S_DONE,
        S_ERR
    } state_t;

    state_t                                r_state;
    state_t                                w_state_nxt;
    logic [CntW-1:0]                       r_cnt;
    logic [CntW-1:0]                       w_cnt_nxt;
    logic [DomW-1:0]                       r_k;
    logic [DomW-1:0]                       w_k_nxt;
    logic [SyncRegWidth-1:0][NumDomains-1:0] r_sync;
    logic [NumDomains-1:0]                 w_ack_s;
    logic                                  w_ack_k;
    logic [DomW-1:0]                       w_low_nack;
    logic [NumDomains-1:0]                 w_rst_n_nxt;
    logic                                  w_busy_nxt;
    logic                                  w_done_nxt;
    logic                                  w_err_nxt;
    logic [DomW-1:0]                       w_err_dom_nxt;

    // Acknowledge synchronizer; resets to "in reset" so power-on needs no ack wait.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SyncRegWidth-2:0], i_ack};
        end
    end

    assign w_ack_s = r_sync[SyncRegWidth-1];
    assign w_ack_k = w_ack_s[r_k];

    // Lowest-index domain still not acknowledging reset, reported on an ASSERT timeout.
    always_comb begin
        w_low_nack = '0;
        for (int j = NumDomains - 1; j >= 0; j--) begin
            if (!w_ack_s[j]) begin
                w_low_nack = DomW'(j);
            end
        end
    end

    // State, cycle counter and release index; reset restarts a full sequence from ASSERT.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_ASSERT;
            r_cnt   <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Next-state logic; an exit condition always takes priority over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    w_state_nxt = S_ASSERT;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = '0;
                end
            end
            S_ASSERT: begin
                if (&w_ack_s) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == AckLast) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_HOLD: begin
                if (r_cnt == HoldLast) begin
                    w_state_nxt = S_RELEASE;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RELEASE: begin
                if (!w_ack_k) begin
                    w_cnt_nxt = '0;
                    if (r_k == DomLast) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_k_nxt = r_k + 1'b1;
                    end
                end else if (r_cnt == AckLast) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
            S_ERR: begin
                if (i_req) begin
                    w_state_nxt = S_ASSERT;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_k_nxt     = '0;
            end
        endcase
    end

    // Output decode of the next state, so registered outputs line up with the state register.
    always_comb begin
        w_rst_n_nxt   = '0;
        w_busy_nxt    = 1'b1;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_err_dom_nxt = '0;
        case (w_state_nxt)
            S_IDLE: begin
                w_rst_n_nxt = '1;
                w_busy_nxt  = 1'b0;
            end
            S_RELEASE: begin
                for (int j = 0; j < NumDomains; j++) begin
                    w_rst_n_nxt[j] = (j <= int'(w_k_nxt));
                end
            end
            S_DONE: begin
                w_rst_n_nxt = '1;
                w_done_nxt  = 1'b1;
            end
            S_ERR: begin
                w_busy_nxt = 1'b0;
                w_err_nxt  = 1'b1;
                if (r_state == S_ERR) begin
                    w_err_dom_nxt = o_err_domain;
                end else if (r_state == S_ASSERT) begin
                    w_err_dom_nxt = w_low_nack;
                end else begin
                    w_err_dom_nxt = r_k;
                end
            end
            default: begin
                w_rst_n_nxt = '0;
            end
        endcase
    end

    // Output registers; domain resets assert asynchronously with the controller reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_rst_n      <= '0;
            o_busy       <= 1'b1;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_err_domain <= '0;
        end else begin
            o_rst_n      <= w_rst_n_nxt;
            o_busy       <= w_busy_nxt;
            o_done       <= w_done_nxt;
            o_err        <= w_err_nxt;
            o_err_domain <= w_err_dom_nxt;
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: bench for rst_seq_ctrl with 3 domains, hold 4, timeout 8.
// Each domain's ack is its o_rst_n inverted and delayed (2 + extra[k]) cycles,
// optionally stuck at 0 or 1. The reference model turns those delays into
// per-phase durations (cycles until every ack is seen, cycles until each release
// ack is seen) and lays out the expected per-cycle outputs in a queue.
module tb_rst_seq_ctrl;

    localparam int ND     = 3;
    localparam int HC     = 4;
    localparam int TO     = 8;
    localparam int SW     = 2;
    localparam int INF    = 1000;
    localparam int SETTLE = 15;
    // Cycles from a change of o_rst_n until the controller acts on the ack:
    // two model delay stages, two synchronizer flops, one decision edge.
    localparam int LAT    = 5;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_req;
    logic [ND-1:0] i_ack = '1;
    logic [ND-1:0] o_rst_n;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [1:0]    o_err_domain;

    int            checks   = 0;
    int            failures = 0;

    logic [ND-1:0] hist [0:7] = '{default: '0};
    int            extra [ND] = '{default: 0};
    logic [ND-1:0] stuck0 = '0;
    logic [ND-1:0] stuck1 = '0;

    logic [7:0]    exp_q [$];
    bit            term_err = 1'b0;
    int            last_ed  = 0;

    rst_seq_ctrl #(
        .NumDomains  (ND),
        .HoldCycles  (HC),
        .AckTimeout  (TO),
        .SyncRegWidth(SW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       (i_req),
        .i_ack       (i_ack),
        .o_rst_n     (o_rst_n),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err),
        .o_err_domain(o_err_domain)
    );

    always #5 i_clk = ~i_clk;

    // Domain model: ack follows inverted o_rst_n through a per-domain delay line.
    always @(negedge i_clk) begin
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = o_rst_n;
        for (int k = 0; k < ND; k++) begin
            if (stuck1[k])      i_ack[k] = 1'b1;
            else if (stuck0[k]) i_ack[k] = 1'b0;
            else                i_ack[k] = ~hist[2 + extra[k]][k];
        end
    end

    function automatic logic [7:0] pk(input logic [ND-1:0] rn, input logic b,
                                      input logic d, input logic e, input logic [1:0] ed);
        return {rn, b, d, e, ed};
    endfunction

    function automatic logic [7:0] obs();
        return {o_rst_n, o_busy, o_done, o_err, o_err_domain};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got rst_n/busy/done/err/dom=%b_%b_%b_%b_%b want=%b_%b_%b_%b_%b",
                     tag, got[7:5], got[4], got[3], got[2], got[1:0],
                     want[7:5], want[4], want[3], want[2], want[1:0]);
        end
    endtask

    task automatic push(input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    function automatic logic [7:0] term_val();
        return term_err ? pk('0, 1'b0, 1'b0, 1'b1, 2'(last_ed)) : pk('1, 1'b0, 1'b0, 1'b0, 2'd0);
    endfunction

    task automatic push_err(input int k);
        push(SETTLE, pk('0, 1'b0, 1'b0, 1'b1, 2'(k)));
        term_err = 1'b1;
        last_ed  = k;
    endtask

    // Expected outputs of one sequence. mode 0: power-on (first ASSERT cycle already
    // observed during reset), 1: started from IDLE, 2: started from ERR.
    task automatic gen_seq(input int mode);
        int            ak [ND];
        int            amax;
        int            r;
        logic [ND-1:0] m;
        amax = 0;
        for (int k = 0; k < ND; k++) begin
            if (mode == 0 || stuck1[k]) ak[k] = 1;
            else if (stuck0[k])         ak[k] = INF;
            else if (mode == 1)         ak[k] = LAT + extra[k];
            else                        ak[k] = 1;
            if (ak[k] > amax) amax = ak[k];
        end
        if (amax > TO) begin
            push(TO, pk('0, 1'b1, 1'b0, 1'b0, 2'd0));
            r = 0;
            for (int k = ND - 1; k >= 0; k--) if (ak[k] > TO) r = k;
            push_err(r);
            return;
        end
        push(amax - ((mode == 0) ? 1 : 0), pk('0, 1'b1, 1'b0, 1'b0, 2'd0));
        push(HC, pk('0, 1'b1, 1'b0, 1'b0, 2'd0));
        for (int k = 0; k < ND; k++) begin
            m = '0;
            for (int j = 0; j <= k; j++) m[j] = 1'b1;
            r = stuck1[k] ? INF : (stuck0[k] ? 1 : LAT + extra[k]);
            if (r > TO) begin
                push(TO, pk(m, 1'b1, 1'b0, 1'b0, 2'd0));
                push_err(k);
                return;
            end
            push(r, pk(m, 1'b1, 1'b0, 1'b0, 2'd0));
        end
        push(1, pk('1, 1'b1, 1'b1, 1'b0, 2'd0));
        push(SETTLE, pk('1, 1'b0, 1'b0, 1'b0, 2'd0));
        term_err = 1'b0;
    endtask

    // Compare one expected entry per cycle; optionally pulse i_req or assert i_rst.
    task automatic run_q(input string tag, input int req_at, input int abort_at);
        int idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            @(negedge i_clk);
            i_req = 1'b0;
            chk($sformatf("%s[%0d]", tag, idx), obs(), exp_q.pop_front());
            if (idx == req_at) i_req = 1'b1;
            if (idx == abort_at) begin
                exp_q.delete();
                i_rst = 1'b0;
            end
            idx++;
        end
    endtask

    // Settle in the current terminal state, then request a sequence.
    // req_at: -1 none, -2 random point while busy, else fixed cycle index.
    task automatic go(input string tag, input int req_at);
        int mode;
        int bl;
        int ra;
        mode = term_err ? 2 : 1;
        push(4, term_val());
        run_q({tag, "_settle"}, -1, -1);
        i_req = 1'b1;
        gen_seq(mode);
        ra = req_at;
        if (req_at == -2) begin
            bl = 0;
            while (bl < exp_q.size() && exp_q[bl][4]) bl++;
            ra = (bl >= 2) ? int'($urandom_range(1, bl - 1)) : -1;
        end
        run_q(tag, ra, -1);
    endtask

    task automatic power_on(input string tag);
        repeat (10) @(negedge i_clk);
        chk({tag, "_rst_state"}, obs(), pk('0, 1'b1, 1'b0, 1'b0, 2'd0));
        i_rst    = 1'b1;
        term_err = 1'b0;
        gen_seq(0);
        run_q(tag, -1, -1);
    endtask

    initial begin
        int ab;
        int sel;
        i_rst = 1'b0;
        i_req = 1'b0;

        power_on("poweron");

        stuck0 = 3'b010;
        go("assert_to", -1);
        stuck0 = '0;
        go("recover_err", -1);

        stuck1 = 3'b100;
        go("release_to", -1);
        stuck1 = '0;
        go("req_in_release", 7);

        extra[1] = 3;
        go("bound8", -1);
        extra[1] = 4;
        go("bound9_assert", -1);
        go("bound9_release", -1);
        extra[1] = 0;
        go("recover_bound", -1);

        // Reset while o_rst_n = 011 must clear it with no clock edge.
        push(4, term_val());
        run_q("midrst_settle", -1, -1);
        i_req = 1'b1;
        gen_seq(1);
        ab = -1;
        for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i][7:5] == 3'b011) ab = i;
        run_q("midrst", -1, ab);
        #1;
        chk("midrst_async", obs(), pk('0, 1'b1, 1'b0, 1'b0, 2'd0));
        power_on("midrst_restart");

        for (int n = 0; n < 10; n++) begin
            stuck0 = '0;
            stuck1 = '0;
            for (int k = 0; k < ND; k++) extra[k] = $urandom_range(0, 4);
            sel = $urandom_range(0, 5);
            if (sel == 0) stuck0[$urandom_range(0, ND - 1)] = 1'b1;
            if (sel == 1) stuck1[$urandom_range(0, ND - 1)] = 1'b1;
            go($sformatf("rand%0d", n), -2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 The module SHALL have parameter NumDomains, default 4, the number of downstream reset domains (1..16).
REQ-002 The module SHALL have parameter HoldCycles, default 16, the number of i_clk cycles all domains stay in reset after all acknowledge (>=1).
REQ-003 The module SHALL have parameter AckTimeout, default 255, the maximum i_clk cycles spent waiting for an acknowledge (>=1).
REQ-004 The module SHALL have parameter SyncRegWidth, default 2, the ack synchronizer depth (>=2).
REQ-005 The module SHALL have port i_clk, input, 1 bit, the controller clock.
REQ-006 The module SHALL have port i_rst, input, 1 bit, the reset: asynchronous, active-low; deassertion arrives synchronous to i_clk.
REQ-007 The module SHALL have port i_req, input, 1 bit, the reset-sequence request, sampled high on a rising edge of i_clk.
REQ-008 The module SHALL have port i_ack, input, NumDomains bits; bit k=1 means domain k reports it is in reset, asynchronous to i_clk.
REQ-009 The module SHALL have port o_rst_n, output, NumDomains bits, an active-low reset per domain.
REQ-010 The module SHALL have port o_busy, output, 1 bit, high while a sequence is in progress.
REQ-011 The module SHALL have port o_done, output, 1 bit, a one-cycle pulse when a sequence completes.
REQ-012 The module SHALL have port o_err, output, 1 bit, a sticky timeout flag.
REQ-013 The module SHALL have port o_err_domain, output, $clog2(NumDomains) bits (min 1), the index of the domain that timed out.

Function
REQ-014 Each i_ack bit SHALL pass through a SyncRegWidth-flop synchronizer (flops reset to 1); the FSM SHALL use only the synchronized value ack_s.
REQ-015 The FSM SHALL have the states IDLE, ASSERT, HOLD, RELEASE, DONE and ERR; all outputs SHALL be registered.
REQ-016 In IDLE: o_rst_n = all 1s and o_busy=0; i_req=1 -> ASSERT.
REQ-017 In ASSERT: o_rst_n = all 0s; when ack_s is all 1s -> HOLD and the cycle counter clears.
REQ-018 In HOLD: o_rst_n = all 0s; ack_s is ignored; after exactly HoldCycles cycles in HOLD -> RELEASE with k=0.
REQ-019 In RELEASE(k): o_rst_n[j]=1 for j<=k, else 0; when ack_s[k]=0, if k=NumDomains-1 -> DONE, else k increments and the counter clears.
REQ-020 Domains SHALL release strictly in ascending index order, one at a time; a re-assertion of ack for an already-released domain is ignored.
REQ-021 The timeout counter SHALL count cycles spent in ASSERT or in the current RELEASE(k); after AckTimeout cycles without the exit condition -> ERR.
REQ-022 If the exit condition and timeout coincide on the same cycle, the exit condition SHALL win.
REQ-023 ERR entry: o_err=1; o_err_domain = lowest k with ack_s[k]=0 (from ASSERT) or = k (from RELEASE); o_rst_n = all 0s.
REQ-024 In ERR: o_busy=0; i_req=1 -> ASSERT, clearing o_err and o_err_domain to 0 on the same edge.
REQ-025 In DONE: o_done=1 for exactly one cycle, o_rst_n = all 1s, then -> IDLE.
REQ-026 o_busy SHALL be 1 in ASSERT, HOLD, RELEASE and DONE.
REQ-027 i_req SHALL be ignored in ASSERT, HOLD, RELEASE and DONE (no restart, no queuing).
REQ-028 The counter width SHALL be $clog2(max(HoldCycles,AckTimeout)+1); the counter SHALL never wrap.

Reset
REQ-029 While i_rst=0: o_rst_n = all 0s (asynchronously), o_busy=1, o_done=0, o_err=0, o_err_domain=0, FSM=ASSERT, counter=0, k=0, synchronizer flops all 1s.
REQ-030 After i_rst deasserts, the FSM SHALL run a full sequence from ASSERT without requiring i_req (power-on sequencing).
REQ-031 An i_rst assertion mid-sequence (any state) SHALL re-assert all o_rst_n immediately and restart per REQ-030.

Verification (NumDomains=3, HoldCycles=4, AckTimeout=8, SyncRegWidth=2; ack model = o_rst_n inverted, delayed 2 cycles)
REQ-032 Power-on: release i_rst -> o_rst_n 000 -> 001 -> 011 -> 111 in order, HOLD lasts exactly 4 cycles, single o_done pulse, then o_busy=0, o_err=0.
REQ-033 ASSERT timeout: i_ack[1] stuck 0, i_req pulse from IDLE -> 8 cycles after entering ASSERT: o_err=1, o_err_domain=1, o_rst_n=000, o_busy=0.
REQ-034 RELEASE timeout: i_ack[2] stuck 1 -> o_rst_n reaches 111, then o_err=1, o_err_domain=2, o_rst_n=000; no o_done.
REQ-035 Recovery/ignore: i_req in ERR with a healthy model -> o_err clears on the next edge and the sequence completes; an i_req pulse during RELEASE produces no restart and exactly one o_done.
REQ-036 Mid-sequence reset: assert i_rst while o_rst_n=011 -> o_rst_n=000 with no clock edge; after release, a full sequence completes per REQ-032.
REQ-037 Boundary: the ack arrives on the 8th waiting cycle -> no error; the ack arrives on the 9th -> error.
